chol_mac_pipe: RTL and testbench
================================

Name: chol_mac_pipe

Overview:
Parametrised pipelined signed multiply-accumulate engine for the Cholesky processing elements. Computes out = addend ± a*b with a fixed latency.
- Addend is either the external c operand or an internal accumulator.
- Valid and tag are carried alongside the data.
- Replaces the fixed 32x32+64 add-only MAC in the PE datapath and adds subtract, accumulate, stall and tag tracking.

Parameters:
A_W, 32, signed width of operand a
B_W, 32, signed width of operand b
P_W, 64, signed width of c, accumulator and out; must be >= A_W+B_W
LAT, 4, total cycles from input sample to out_valid; legal range 2..8
TAG_W, 4, width of the user tag carried with each operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
clken  in  1  global clock enable; 0 freezes every register
in_valid  in  1  input operation valid
a  in  A_W  signed multiplicand
b  in  B_W  signed multiplier
c  in  P_W  signed external addend
in_sub  in  1  1: addend - a*b; 0: addend + a*b
in_acc  in  1  1: addend is the accumulator; 0: addend is c
in_clr  in  1  with in_acc=1, the accumulator is taken as 0 for this op
in_tag  in  TAG_W  user tag
out_valid  out  1  result valid
out  out  P_W  signed result
out_tag  out  TAG_W  tag of the result
acc  out  P_W  current accumulator value

Behaviour:
- Reset (async assert, sync release): all pipeline valid bits=0, out=0, out_tag=0, acc=0, out_valid=0.
- Pipeline stages and clken:
  - Ops are sampled when clken=1 and in_valid=1. Inputs are ignored when in_valid=0; a bubble propagates.
  - Stages 1..LAT-1: registered signed product a*b, width A_W+B_W, sign-extended to P_W. Pipeline the multiply across these stages.
  - Stage LAT: add/sub plus output register.
  - c, in_sub, in_acc, in_clr and in_tag are delayed alongside the product to stage LAT.
  - clken=0 holds all state, including out, out_valid and acc. Latency counts enabled cycles only.
- Final stage:
  - addend = in_acc ? (in_clr ? 0 : acc) : c_delayed.
  - result = in_sub ? addend - prod : addend + prod.
  - Computed modulo 2^P_W: two's-complement wrap, no flag.
- Output registers:
  - out_valid <= stage-LAT valid.
  - When stage-LAT valid=1, out and out_tag are registered; otherwise out holds its last value.
- Accumulator:
  - acc <= result on every valid op with in_acc=1. Ops with in_acc=0 leave acc unchanged.
  - Feedback is single-cycle at the final stage, so back-to-back accumulate ops (one per enabled cycle) see the previous result with no hazard.
- Throughput: one op per enabled cycle, in-order, no backpressure.
- Reset mid-operation: all in-flight ops are discarded and acc clears. No out_valid is produced for ops sampled before reset.
- Simultaneous in_clr with in_acc=0: in_clr is ignored.

Optional Feature:
CHOL_MAC_SAT_EN
- Defined: final add/sub saturates to [-2^(P_W-1), 2^(P_W-1)-1]. The accumulator stores the saturated value. An extra output `sat` (1 bit) is a sticky flag, set on any saturation and cleared only by rst.
- Undefined: results wrap, and the `sat` port does not exist.

Decomposition:
- Package chol_mac_pkg holds:
  - the op-control struct (sub, acc, clr, tag);
  - default width constants;
  - the LAT legality bounds, checked with a generate-time error on a bad LAT.
- One sub-module, chol_mac_mult: parametrised signed pipelined multiplier of LAT-1 stages with clken. The top holds the control delay line, final add/sub, accumulator and output registers.

Test Plan:
1. Single op, LAT=4: a=3, b=-5, c=100, in_sub=0, in_acc=0 -> exactly 4 enabled cycles later out_valid=1, out=85; acc stays 0.
2. Subtract: a=7, b=6, c=50, in_sub=1 -> out=8; tag=0xA -> out_tag=0xA.
3. Back-to-back accumulate: (2,3,clr=1), (4,5), (-1,10) with in_acc=1 on consecutive cycles -> outs 6, 26, 16 on consecutive cycles; final acc=16.
4. Stall: deassert clken for 3 cycles with 2 ops in flight -> out, out_valid and acc frozen. Results emerge after 4 total enabled cycles, unchanged.
5. Wrap/saturate: c=2^63-1, a=1, b=1, add -> wrap build: out=-2^63. With CHOL_MAC_SAT_EN: out=2^63-1, sat=1.
6. Async reset with 3 ops in flight and acc=16 -> immediately out=0, acc=0, out_valid=0. No result appears after reset release.

Source files
------------

// File: rtl/chol_mac_pkg.sv
// Shared types and default sizing for the Cholesky PE multiply-accumulate pipe.
// The CHOL_MAC_SAT_EN macro (used by chol_mac_pipe) selects saturating arithmetic.
package chol_mac_pkg;

  localparam int unsigned A_W_DEF   = 32;
  localparam int unsigned B_W_DEF   = 32;
  localparam int unsigned P_W_DEF   = 64;
  localparam int unsigned LAT_DEF   = 4;
  localparam int unsigned TAG_W_DEF = 4;

  localparam int unsigned LAT_MIN   = 2;
  localparam int unsigned LAT_MAX   = 8;

  // The tag field is sized for the widest supported tag; narrower tags are zero-extended.
  localparam int unsigned TAG_W_MAX = 16;

  typedef struct packed {
    logic                 sub;
    logic                 acc;
    logic                 clr;
    logic [TAG_W_MAX-1:0] tag;
  } op_ctl_t;

  function automatic bit lat_ok(input int unsigned lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/chol_mac_mult.sv
// Signed multiplier with a STAGES-deep registered product, sign-extended to P_W.
module chol_mac_mult
  import chol_mac_pkg::*;
#(
  parameter int unsigned A_W    = A_W_DEF,
  parameter int unsigned B_W    = B_W_DEF,
  parameter int unsigned P_W    = P_W_DEF,
  parameter int unsigned STAGES = LAT_DEF - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] prod
);

  localparam int unsigned M_W = A_W + B_W;

  logic signed [M_W-1:0] mul_c;
  logic signed [P_W-1:0] pipe_q [STAGES];

  assign mul_c = M_W'(a) * M_W'(b);

  // Trailing stages give synthesis room to retime the multiplier array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) pipe_q[i] <= '0;
    end else if (clken) begin
      pipe_q[0] <= P_W'(mul_c);
      for (int i = 1; i < int'(STAGES); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign prod = pipe_q[STAGES-1];

endmodule

// File: rtl/chol_mac_pipe.sv
// Pipelined signed MAC: out = addend +/- a*b after LAT enabled cycles, addend = c or accumulator.
// Define CHOL_MAC_SAT_EN for saturating add/sub and a sticky sat output.
module chol_mac_pipe
  import chol_mac_pkg::*;
#(
  parameter int unsigned A_W   = A_W_DEF,
  parameter int unsigned B_W   = B_W_DEF,
  parameter int unsigned P_W   = P_W_DEF,
  parameter int unsigned LAT   = LAT_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  input  logic signed [P_W-1:0] c,
  input  logic                  in_sub,
  input  logic                  in_acc,
  input  logic                  in_clr,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  output logic signed [P_W-1:0] out,
  output logic [TAG_W-1:0]      out_tag,
  output logic signed [P_W-1:0] acc
`ifdef CHOL_MAC_SAT_EN
  ,
  output logic                  sat
`endif
);

  localparam int unsigned STG = LAT - 1;

  if (!lat_ok(LAT)) begin : g_bad_lat
    $error("chol_mac_pipe: LAT=%0d outside %0d..%0d", LAT, LAT_MIN, LAT_MAX);
  end
  if (P_W < A_W + B_W) begin : g_bad_pw
    $error("chol_mac_pipe: P_W=%0d narrower than A_W+B_W", P_W);
  end
  if (TAG_W > TAG_W_MAX) begin : g_bad_tag
    $error("chol_mac_pipe: TAG_W=%0d exceeds %0d", TAG_W, TAG_W_MAX);
  end

  logic                  vld_q [STG];
  op_ctl_t               ctl_q [STG];
  logic signed [P_W-1:0] c_q   [STG];

  logic                  vld_l;
  op_ctl_t               ctl_l;
  logic signed [P_W-1:0] c_l;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] addend;
  logic signed [P_W-1:0] result;

  chol_mac_mult #(
    .A_W    (A_W),
    .B_W    (B_W),
    .P_W    (P_W),
    .STAGES (STG)
  ) u_mult (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .a     (a),
    .b     (b),
    .prod  (prod)
  );

  // Control and addend delay line, kept in step with the multiplier stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STG); i++) begin
        vld_q[i] <= 1'b0;
        ctl_q[i] <= '0;
        c_q[i]   <= '0;
      end
    end else if (clken) begin
      vld_q[0] <= in_valid;
      ctl_q[0] <= '{sub: in_sub, acc: in_acc, clr: in_clr, tag: TAG_W_MAX'(in_tag)};
      c_q[0]   <= c;
      for (int i = 1; i < int'(STG); i++) begin
        vld_q[i] <= vld_q[i-1];
        ctl_q[i] <= ctl_q[i-1];
        c_q[i]   <= c_q[i-1];
      end
    end
  end

  assign vld_l  = vld_q[STG-1];
  assign ctl_l  = ctl_q[STG-1];
  assign c_l    = c_q[STG-1];
  assign addend = ctl_l.acc ? (ctl_l.clr ? '0 : acc) : c_l;

`ifdef CHOL_MAC_SAT_EN
  logic [P_W:0] sum_x;
  logic         ovf;

  // One guard bit exposes signed overflow; clamp towards the sign of the true result.
  assign sum_x  = ctl_l.sub ? ({addend[P_W-1], addend} - {prod[P_W-1], prod})
                            : ({addend[P_W-1], addend} + {prod[P_W-1], prod});
  assign ovf    = sum_x[P_W] ^ sum_x[P_W-1];
  assign result = !ovf       ? sum_x[P_W-1:0] :
                  sum_x[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
`else
  assign result = ctl_l.sub ? (addend - prod) : (addend + prod);
`endif

  // Final stage: output, tag and single-cycle accumulator feedback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
      acc       <= '0;
`ifdef CHOL_MAC_SAT_EN
      sat       <= 1'b0;
`endif
    end else if (clken) begin
      out_valid <= vld_l;
      if (vld_l) begin
        out     <= result;
        out_tag <= TAG_W'(ctl_l.tag);
        if (ctl_l.acc) acc <= result;
`ifdef CHOL_MAC_SAT_EN
        if (ovf) sat <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_chol_mac_pipe.sv
// Scoreboard bench for chol_mac_pipe (default parameters, LAT=4); honours CHOL_MAC_SAT_EN.
module tb_chol_mac_pipe;

  localparam int unsigned LAT = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               clken;
  logic               in_valid;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic signed [63:0] c;
  logic               in_sub;
  logic               in_acc;
  logic               in_clr;
  logic [3:0]         in_tag;
  logic               out_valid;
  logic signed [63:0] out;
  logic [3:0]         out_tag;
  logic signed [63:0] acc;
`ifdef CHOL_MAC_SAT_EN
  logic               sat;
`endif

  chol_mac_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_sub    (in_sub),
    .in_acc    (in_acc),
    .in_clr    (in_clr),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out       (out),
    .out_tag   (out_tag),
    .acc       (acc)
`ifdef CHOL_MAC_SAT_EN
    ,
    .sat       (sat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] out;
    logic [3:0]  tag;
    logic [63:0] acc;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ecnt = 0;
  bit   fired = 1'b0;

  localparam logic [63:0] P_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] P_MIN = 64'h8000_0000_0000_0000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Enabled-edge counter and a flag marking whether the last edge advanced the pipe.
  always @(posedge clk) begin
    fired = clken && !rst;
    if (clken && !rst) ecnt++;
  end

  // Monitor: every freshly registered result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (fired && !rst && out_valid) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got out=%0h tag=%0h, required no result", out, out_tag);
      end else begin
        mon_e = sbq.pop_front();
        check("out",      out,            mon_e.out);
        check("out_tag",  64'(out_tag),   64'(mon_e.tag));
        check("acc",      acc,            mon_e.acc);
        check("latency",  64'(ecnt),      64'(mon_e.cyc));
      end
    end
  end

  task automatic issue(input logic signed [31:0] ia, input logic signed [31:0] ib,
                       input logic signed [63:0] ic, input logic isub, input logic iacc,
                       input logic iclr, input logic [3:0] itag, input bit push,
                       input logic [63:0] xout, input logic [63:0] xacc);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; c = ic;
    in_sub = isub; in_acc = iacc; in_clr = iclr; in_tag = itag;
    in_valid = 1'b1;
    if (push) begin
      e.out = xout;
      e.tag = itag;
      e.acc = xacc;
      e.cyc = ecnt + int'(LAT);
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sub = 1'b0; in_acc = 1'b0; in_clr = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    check(nm, 64'(sbq.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1; in_valid = 1'b0;
    a = '0; b = '0; c = '0; in_sub = 1'b0; in_acc = 1'b0; in_clr = 1'b0; in_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out",       out,            64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_acc",       acc,            64'd0);
    rst = 1'b0;

    // Single add and a tagged subtract
    issue(3, -5, 100, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 64'd85, 64'd0);
    idle();
    drain("drain_single");
    issue(7, 6, 50, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 64'd8, 64'd0);
    idle();
    drain("drain_sub");

    // Back-to-back accumulate, first op clears
    issue(2, 3, 999, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 64'd6, 64'd6);
    issue(4, 5, 999, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 64'd26, 64'd26);
    issue(-1, 10, 999, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 64'd16, 64'd16);
    idle();
    drain("drain_acc");
    check("acc_final", acc, 64'd16);

    // Stall with two ops in flight
    issue(10, 10, 1, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 64'd101, 64'd16);
    issue(-3, 4, 0, 1'b1, 1'b0, 1'b0, 4'h6, 1'b1, 64'd12, 64'd16);
    @(negedge clk);
    in_valid = 1'b0; in_sub = 1'b0; clken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd0);
      check("stall_out",       out,            64'd16);
      check("stall_acc",       acc,            64'd16);
    end
    clken = 1'b1;
    drain("drain_stall");

    // Overflow boundary
`ifdef CHOL_MAC_SAT_EN
    check("sat_before", 64'(sat), 64'd0);
    issue(1, 1, P_MAX, 1'b0, 1'b0, 1'b0, 4'h7, 1'b1, P_MAX, 64'd16);
`else
    issue(1, 1, P_MAX, 1'b0, 1'b0, 1'b0, 4'h7, 1'b1, P_MIN, 64'd16);
`endif
    idle();
    drain("drain_ovf");
`ifdef CHOL_MAC_SAT_EN
    check("sat_after", 64'(sat), 64'd1);
`endif

    // Async reset with three accumulate ops in flight
    check("acc_pre_reset", acc, 64'd16);
    issue(1, 1, 0, 1'b0, 1'b1, 1'b0, 4'h8, 1'b0, 64'd0, 64'd0);
    issue(1, 1, 0, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 64'd0, 64'd0);
    issue(1, 1, 0, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    in_valid = 1'b0; in_acc = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out",       out,            64'd0);
    check("arst_acc",       acc,            64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
`ifdef CHOL_MAC_SAT_EN
    check("arst_sat", 64'(sat), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_acc", acc, 64'd0);

    // Pipe is usable again after reset
    issue(2, 2, 0, 1'b0, 1'b1, 1'b1, 4'hC, 1'b1, 64'd4, 64'd4);
    idle();
    drain("drain_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
